// File: rtl/de_reg_calcpc_mw.sv
// D-to-E pipeline register for a multi-lane decode group: younger-lane kill after a jump,
// misprediction/stall bubbling or holding, and a saturating count of dropped valid lanes.
module de_reg_calcpc_mw #(
    parameter int LANES         = 2,
    parameter int PC_W          = 13,
    parameter int IMM_W         = 13,
    parameter int HOLD_ON_STALL = 0,
    parameter int CNT_W         = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   fail_predict,
    input  logic                   cnt_clr,
    input  logic [LANES-1:0]       validD,
    input  logic [2*LANES-1:0]     branch_numberD,
    input  logic [PC_W*LANES-1:0]  pcDj,
    input  logic [IMM_W*LANES-1:0] immDj,
    input  logic [2*LANES-1:0]     jump_codeDj,
    input  logic [3*LANES-1:0]     branch_codeDj,
    output logic [LANES-1:0]       validE,
    output logic [2*LANES-1:0]     branch_numberE,
    output logic [PC_W*LANES-1:0]  pcEj,
    output logic [IMM_W*LANES-1:0] immEj,
    output logic [2*LANES-1:0]     jump_codeEj,
    output logic [3*LANES-1:0]     branch_codeEj,
    output logic [CNT_W-1:0]       squash_cnt
);

    localparam bit                HOLD    = (HOLD_ON_STALL != 0);
    localparam int                SUM_W   = CNT_W + 3;
    localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [LANES-1:0]       valid_q, valid_d;
    logic [2*LANES-1:0]     bn_q, bn_d;
    logic [PC_W*LANES-1:0]  pc_q, pc_d;
    logic [IMM_W*LANES-1:0] imm_q, imm_d;
    logic [2*LANES-1:0]     jc_q, jc_d;
    logic [3*LANES-1:0]     bc_q, bc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [LANES-1:0] killed;
    logic [LANES-1:0] keep;
    logic [LANES-1:0] drop_mask;
    logic [2:0]       drop_cnt;
    logic [SUM_W-1:0] sum;
    logic             older_jump;
    logic             load;

    // A lane is killed when any older valid lane in the same group is a jump.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        killed     = '0;
        older_jump = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            killed[i] = older_jump;
            if (validD[i] && (jump_codeDj[2*i +: 2] != 2'b00)) older_jump = 1'b1;
        end
    end

    assign load = fail_predict | ~stall | ~HOLD;
    assign keep = (fail_predict | stall) ? '0 : (validD & ~killed);

    always_comb begin
        valid_d = valid_q;
        bn_d    = bn_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        jc_d    = jc_q;
        bc_d    = bc_q;
        if (load) begin
            valid_d = keep;
            bn_d    = branch_numberD;
            pc_d    = pcDj;
            imm_d   = immDj;
            for (int i = 0; i < LANES; i++) begin
                jc_d[2*i +: 2] = keep[i] ? jump_codeDj[2*i +: 2]   : 2'b00;
                bc_d[3*i +: 3] = keep[i] ? branch_codeDj[3*i +: 3] : 3'b000;
            end
        end
    end

    // Wide sum so a multi-lane add that crosses the maximum still saturates.
    always_comb begin
        drop_mask = fail_predict ? validD : (stall ? '0 : (validD & killed));
        drop_cnt  = '0;
        for (int i = 0; i < LANES; i++) drop_cnt = drop_cnt + 3'(drop_mask[i]);
        sum   = SUM_W'(cnt_q) + SUM_W'(drop_cnt);
        cnt_d = cnt_clr ? '0 : ((sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum));
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) begin
            valid_q <= '0;
            bn_q    <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            jc_q    <= '0;
            bc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            bn_q    <= bn_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            jc_q    <= jc_d;
            bc_q    <= bc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign validE         = valid_q;
    assign branch_numberE = bn_q;
    assign pcEj           = pc_q;
    assign immEj          = imm_q;
    assign jump_codeEj    = jc_q;
    assign branch_codeEj  = bc_q;
    assign squash_cnt     = cnt_q;

endmodule

// File: tb/tb_de_reg_calcpc_mw.sv
// Scoreboard bench: two instances (hold-on-stall with 3-bit counter, bubble-on-stall with 16-bit
// counter) share stimulus; a lane-level reference model predicts each E-stage state.
module tb_de_reg_calcpc_mw;

    typedef struct packed {
        logic [1:0]  valid;
        logic [3:0]  bn;
        logic [25:0] pc;
        logic [25:0] imm;
        logic [3:0]  jc;
        logic [5:0]  bc;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, stall, fail_predict, cnt_clr;
    logic [1:0]  validD;
    logic [3:0]  branch_numberD;
    logic [25:0] pcDj, immDj;
    logic [3:0]  jump_codeDj;
    logic [5:0]  branch_codeDj;

    logic [1:0]  h_valid, b_valid;
    logic [3:0]  h_bn, b_bn, h_jc, b_jc;
    logic [25:0] h_pc, b_pc, h_imm, b_imm;
    logic [5:0]  h_bc, b_bc;
    logic [2:0]  h_cnt;
    logic [15:0] b_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t m_h = '0, m_b = '0;
    exp_t q_h[$], q_b[$];

    always #5 CLK = ~CLK;

    de_reg_calcpc_mw #(.LANES(2), .PC_W(13), .IMM_W(13), .HOLD_ON_STALL(1), .CNT_W(3)) dut_h (
        .CLK(CLK), .RST(RST), .stall(stall), .fail_predict(fail_predict), .cnt_clr(cnt_clr),
        .validD(validD), .branch_numberD(branch_numberD), .pcDj(pcDj), .immDj(immDj),
        .jump_codeDj(jump_codeDj), .branch_codeDj(branch_codeDj),
        .validE(h_valid), .branch_numberE(h_bn), .pcEj(h_pc), .immEj(h_imm),
        .jump_codeEj(h_jc), .branch_codeEj(h_bc), .squash_cnt(h_cnt));

    de_reg_calcpc_mw #(.LANES(2), .PC_W(13), .IMM_W(13), .HOLD_ON_STALL(0), .CNT_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .stall(stall), .fail_predict(fail_predict), .cnt_clr(cnt_clr),
        .validD(validD), .branch_numberD(branch_numberD), .pcDj(pcDj), .immDj(immDj),
        .jump_codeDj(jump_codeDj), .branch_codeDj(branch_codeDj),
        .validE(b_valid), .branch_numberE(b_bn), .pcEj(b_pc), .immEj(b_imm),
        .jump_codeEj(b_jc), .branch_codeEj(b_bc), .squash_cnt(b_cnt));

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk lanes oldest-first; once an older valid jump is seen, younger valid lanes drop.
    function automatic exp_t step(exp_t cur, bit hold, int maxc);
        exp_t n      = cur;
        int   drop   = 0;
        int   sum;
        bit   jumped = 1'b0;
        if (RST) return '0;
        if (!(stall && !fail_predict && hold)) begin
            n.bn    = branch_numberD;
            n.pc    = pcDj;
            n.imm   = immDj;
            n.valid = '0;
            n.jc    = '0;
            n.bc    = '0;
            for (int l = 0; l < 2; l++) begin
                if (validD[l] && !fail_predict && !stall) begin
                    if (jumped) drop++;
                    else begin
                        n.valid[l]      = 1'b1;
                        n.jc[l*2 +: 2]  = jump_codeDj[l*2 +: 2];
                        n.bc[l*3 +: 3]  = branch_codeDj[l*3 +: 3];
                    end
                end
                if (validD[l] && jump_codeDj[l*2 +: 2] != 0) jumped = 1'b1;
            end
        end
        if (fail_predict) drop = int'(validD[0]) + int'(validD[1]);
        sum = int'(cur.cnt) + drop;
        if (sum > maxc) sum = maxc;
        n.cnt = cnt_clr ? 16'd0 : 16'(sum);
        return n;
    endfunction

    task automatic drive(bit r, bit f, bit s, bit c, logic [1:0] v, logic [3:0] b,
                         logic [25:0] p, logic [25:0] im, logic [3:0] j, logic [5:0] br);
        @(negedge CLK);
        RST = r; fail_predict = f; stall = s; cnt_clr = c;
        validD = v; branch_numberD = b; pcDj = p; immDj = im; jump_codeDj = j; branch_codeDj = br;
        m_h = step(m_h, 1'b1, 7);
        m_b = step(m_b, 1'b0, 65535);
        q_h.push_back(m_h);
        q_b.push_back(m_b);
    endtask

    task automatic drive_rand(bit r, bit f, bit s, bit c);
        drive(r, f, s, c, 2'($urandom), 4'($urandom), 26'($urandom), 26'($urandom),
              4'($urandom_range(0, 3) == 0 ? $urandom : 0), 6'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q_h.size() != 0) begin
                e = q_h.pop_front();
                check("h_valid", 64'(h_valid), 64'(e.valid));
                check("h_bn",    64'(h_bn),    64'(e.bn));
                check("h_pc",    64'(h_pc),    64'(e.pc));
                check("h_imm",   64'(h_imm),   64'(e.imm));
                check("h_jc",    64'(h_jc),    64'(e.jc));
                check("h_bc",    64'(h_bc),    64'(e.bc));
                check("h_cnt",   64'(h_cnt),   64'(e.cnt));
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_valid", 64'(b_valid), 64'(e.valid));
                check("b_bn",    64'(b_bn),    64'(e.bn));
                check("b_pc",    64'(b_pc),    64'(e.pc));
                check("b_imm",   64'(b_imm),   64'(e.imm));
                check("b_jc",    64'(b_jc),    64'(e.jc));
                check("b_bc",    64'(b_bc),    64'(e.bc));
                check("b_cnt",   64'(b_cnt),   64'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        RST = 1'b1; stall = 1'b0; fail_predict = 1'b0; cnt_clr = 1'b0;
        validD = '0; branch_numberD = '0; pcDj = '0; immDj = '0; jump_codeDj = '0; branch_codeDj = '0;

        drive(1, 0, 0, 0, 2'b00, 4'h0, 26'h0, 26'h0, 4'h0, 6'h0);
        // Two valid lanes, no control flow.
        drive(0, 0, 0, 0, 2'b11, 4'h6, {13'h040, 13'h03C}, {13'h011, 13'h022}, 4'h0, 6'h0);
        // Lane 0 jumps: lane 1 killed and its codes cleared.
        drive(0, 0, 0, 0, 2'b11, 4'h9, {13'h048, 13'h044}, {13'h001, 13'h002}, 4'b0001, 6'b101_000);
        // Misprediction beats stall.
        drive(0, 1, 1, 0, 2'b11, 4'h3, {13'h050, 13'h04C}, 26'h5, 4'b1010, 6'b011_010);
        // Capture then three stalls with changing D.
        drive(0, 0, 0, 0, 2'b11, 4'h5, {13'h060, 13'h05C}, 26'h77, 4'b0000, 6'b010_001);
        for (int k = 0; k < 3; k++)
            drive(0, 0, 1, 0, 2'b11, 4'(k), {13'h100 + 13'(k), 13'h200 + 13'(k)}, 26'(k * 3),
                  4'b0000, 6'b001_001);
        // Eight drops saturate the 3-bit counter; then clear beats a same-cycle increment.
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 2'b11, 4'h1, 26'h123, 26'h456, 4'h0, 6'h0);
        drive(0, 1, 0, 1, 2'b11, 4'h2, 26'h321, 26'h654, 4'h0, 6'h0);
        drive(0, 0, 0, 0, 2'b10, 4'h2, 26'h321, 26'h654, 4'b0100, 6'h0);

        for (int k = 0; k < 400; k++)
            drive_rand($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);

        // Reset during a valid stream with a simultaneous misprediction.
        drive(0, 0, 0, 0, 2'b11, 4'hA, 26'h3FF_FFFF, 26'h1234, 4'b0100, 6'b111_111);
        drive(1, 1, 0, 0, 2'b11, 4'hB, 26'h2AA_AAAA, 26'h4321, 4'b0000, 6'b111_111);
        drive(0, 0, 0, 0, 2'b01, 4'hC, 26'h0000_123, 26'h0042, 4'b0000, 6'b000_100);

        for (int k = 0; k < 10 && (q_h.size() != 0 || q_b.size() != 0); k++) @(posedge CLK);
        #2;
        total++;
        if (q_h.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: pending h=%0d b=%0d required 0", q_h.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
